fetch_pc: RTL and testbench
===========================

# fetch_pc

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the decode stage. Holds the program counter and drives the instruction-memory address. Pipelines the next-PC value to the ID and EX stages for JAL link and branch-offset arithmetic. Redirects on taken branches and jumps, and freezes on decode stalls (load-use hazard, halt). Keeps two performance counters.

## Interface
- PC_W, 16, width of PC and instruction-memory address (word addressed)
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of both performance counters
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_IM_ID  in  1  from decode; hold PC and IM_ID flops (hazard or halt)
- flow_change_ID_EX  in  1  taken branch / JAL / JR resolved in EX this cycle
- dst_ID_EX  in  PC_W  redirect target computed by EX
- iaddr  out  PC_W  instruction-memory address (= pc register, combinational read)
- nxt_pc_IM_ID  out  PC_W  PC+1 of the instruction in IM_ID
- nxt_pc_ID_EX  out  PC_W  PC+1 of the instruction in ID_EX (NPC2SRC1 source)
- fetch_cnt  out  CNT_W  sequential advances of PC, saturating
- redirect_cnt  out  CNT_W  accepted redirects, saturating

## Operation
- Registers: pc, nxt_pc_IM_ID, nxt_pc_ID_EX, fetch_cnt, redirect_cnt. All are async-reset.
- Reset values:
  - pc = RESET_PC.
  - nxt_pc_IM_ID = 0, nxt_pc_ID_EX = 0.
  - Both counters = 0.
- iaddr = pc at all times. IM returns instr combinationally; decode flops it.
- PC update, in priority order:
  1. flow_change_ID_EX = 1: pc <= dst_ID_EX, regardless of stall_IM_ID. redirect_cnt += 1.
  2. else stall_IM_ID = 1: pc holds.
  3. else: pc <= pc + 1, mod 2^PC_W (wraps from all-ones to 0). fetch_cnt += 1.
- nxt_pc_IM_ID <= pc + 1 (mod 2^PC_W) when stall_IM_ID = 0; otherwise it holds. It updates even on a redirect cycle: the captured instruction is the wrong-path one and decode flushes it.
- nxt_pc_ID_EX <= nxt_pc_IM_ID every cycle. The ID_EX stage never stalls, matching decode.
- Counters saturate at 2^CNT_W - 1. They never wrap.
- No internal state machine beyond the registers. Halt is handled entirely by decode holding stall_IM_ID high. Once stall_IM_ID is set for halt, pc stays frozen until reset, unless an older redirect arrives.
- A reset asserted mid-operation returns every register to its reset value immediately, with no clock required. The first fetch after deassertion uses RESET_PC.

## Timing
- Zero-cycle address path: iaddr changes in the same cycle pc is written (register output only).
- Sequential fetch: instruction at address A is presented in cycle N and captured in IM_ID at edge N→N+1. nxt_pc_IM_ID = A+1 from N+1. nxt_pc_ID_EX = A+1 from N+2.
- Redirect:
  - flow_change_ID_EX sampled high at edge E gives pc = dst_ID_EX after E.
  - The target instruction enters IM_ID at edge E+1.
  - The two instructions fetched before the target are squashed by decode's flow_change_ID_EX / flow_change_EX_DM flush. This block does not squash them itself.
- Stall: each stalled cycle holds pc and nxt_pc_IM_ID. nxt_pc_ID_EX still advances, copying the held value.
- Simultaneous flow_change_ID_EX and stall_IM_ID: the redirect wins. pc <= dst_ID_EX and nxt_pc_IM_ID holds.
- Back-to-back redirects on consecutive cycles: each is applied, the last one wins, and redirect_cnt increments each time.

## Test plan
- Reset: hold rst_n low with RESET_PC=0x0010 → iaddr=0x0010, nxt_pc_*=0, counters=0. Release with no stall → iaddr 0x0011, 0x0012 on the next two edges. nxt_pc_IM_ID=0x0011 one edge after release, nxt_pc_ID_EX=0x0011 the edge after.
- Stall: stall_IM_ID high for 3 cycles at pc=0x0005 → iaddr stays 0x0005, nxt_pc_IM_ID holds 0x0005, fetch_cnt unchanged. Resumes 0x0006 on the first unstalled edge.
- Redirect: flow_change_ID_EX=1, dst_ID_EX=0x0100 at pc=0x0020 → iaddr=0x0100 next cycle, redirect_cnt=1, fetch_cnt unchanged that cycle. Repeat with stall_IM_ID=1 in the same cycle → still 0x0100.
- Wrap: pc=0xFFFF with no stall → pc=0x0000 and nxt_pc_IM_ID=0x0000.
- Saturation: run with CNT_W=4 for 20 unstalled cycles → fetch_cnt stops at 0xF. 17 consecutive redirects → redirect_cnt=0xF.
- Async reset mid-run: assert rst_n low between clock edges at pc=0x0042 → all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/fetch_pc.sv
// fetch_pc: IF-stage program counter with redirect/stall handling, next-PC pipeline and saturating perf counters
module fetch_pc #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_IM_ID,
    input  logic             flow_change_ID_EX,
    input  logic [PC_W-1:0]  dst_ID_EX,
    output logic [PC_W-1:0]  iaddr,
    output logic [PC_W-1:0]  nxt_pc_IM_ID,
    output logic [PC_W-1:0]  nxt_pc_ID_EX,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_nxt_pc_im_id;
    logic [PC_W-1:0]  r_nxt_pc_id_ex;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [PC_W-1:0]  w_pc_inc;
    logic             w_seq;
    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_seq        = !flow_change_ID_EX && !stall_IM_ID;
    assign iaddr        = r_pc;
    assign nxt_pc_IM_ID = r_nxt_pc_im_id;
    assign nxt_pc_ID_EX = r_nxt_pc_id_ex;
    assign fetch_cnt    = r_fetch_cnt;
    assign redirect_cnt = r_redirect_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_nxt_pc_im_id <= '0;
            r_nxt_pc_id_ex <= '0;
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_pc           <= flow_change_ID_EX ? dst_ID_EX : stall_IM_ID ? r_pc : w_pc_inc;
            r_nxt_pc_im_id <= stall_IM_ID ? r_nxt_pc_im_id : w_pc_inc;
            r_nxt_pc_id_ex <= r_nxt_pc_im_id;
            if (w_seq && r_fetch_cnt != '1)
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            if (flow_change_ID_EX && r_redirect_cnt != '1)
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed vectors with hand-computed expectations, checked by a queue-based monitor
module tb_fetch_pc;
    logic        clk;
    logic        rst_n;
    logic        stall_IM_ID;
    logic        flow_change_ID_EX;
    logic [15:0] dst_ID_EX;
    logic [15:0] iaddr;
    logic [15:0] nxt_pc_IM_ID;
    logic [15:0] nxt_pc_ID_EX;
    logic [3:0]  fetch_cnt;
    logic [3:0]  redirect_cnt;
    logic        probe;
    typedef struct {
        int          id;
        logic [15:0] pc;
        logic [15:0] nim;
        logic [15:0] nex;
        logic [3:0]  fc;
        logic [3:0]  rc;
    } exp_t;
    exp_t q[$];
    int n_vec;
    int n_bad;
    int n_id;
    fetch_pc #(.PC_W(16), .RESET_PC(16'h0010), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall_IM_ID(stall_IM_ID),
        .flow_change_ID_EX(flow_change_ID_EX),
        .dst_ID_EX(dst_ID_EX),
        .iaddr(iaddr),
        .nxt_pc_IM_ID(nxt_pc_IM_ID),
        .nxt_pc_ID_EX(nxt_pc_ID_EX),
        .fetch_cnt(fetch_cnt),
        .redirect_cnt(redirect_cnt)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h expected %h", id, name, act, req);
        end
    endtask
    // Monitor: wakes after each clock edge, or on a probe pulse for between-edge checks
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge probe);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("iaddr", e.id, iaddr, e.pc);
                chk("nxt_pc_IM_ID", e.id, nxt_pc_IM_ID, e.nim);
                chk("nxt_pc_ID_EX", e.id, nxt_pc_ID_EX, e.nex);
                chk("fetch_cnt", e.id, {12'h0, fetch_cnt}, {12'h0, e.fc});
                chk("redirect_cnt", e.id, {12'h0, redirect_cnt}, {12'h0, e.rc});
            end
        end
    end
    task automatic push(input logic [15:0] pc, nim, nex, input logic [3:0] fc, rc);
        exp_t e;
        e.id = n_id;
        e.pc = pc;
        e.nim = nim;
        e.nex = nex;
        e.fc = fc;
        e.rc = rc;
        n_id++;
        q.push_back(e);
    endtask
    // Drive inputs on the falling edge; expectation is for the state after the next rising edge
    task automatic step(input logic r, s, f, input logic [15:0] d,
                        input logic [15:0] pc, nim, nex, input logic [3:0] fc, rc);
        @(negedge clk);
        rst_n = r;
        stall_IM_ID = s;
        flow_change_ID_EX = f;
        dst_ID_EX = d;
        push(pc, nim, nex, fc, rc);
    endtask
    initial begin
        n_vec = 0;
        n_bad = 0;
        n_id = 0;
        probe = 0;
        rst_n = 0;
        stall_IM_ID = 0;
        flow_change_ID_EX = 0;
        dst_ID_EX = 0;
        step(0, 0, 0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        step(1, 0, 0, 16'h0000, 16'h0011, 16'h0011, 16'h0000, 1, 0);
        step(1, 0, 0, 16'h0000, 16'h0012, 16'h0012, 16'h0011, 2, 0);
        step(1, 0, 1, 16'h0004, 16'h0004, 16'h0013, 16'h0012, 2, 1);
        step(1, 0, 0, 16'h0000, 16'h0005, 16'h0005, 16'h0013, 3, 1);
        step(1, 1, 0, 16'h0000, 16'h0005, 16'h0005, 16'h0005, 3, 1);
        step(1, 1, 0, 16'h0000, 16'h0005, 16'h0005, 16'h0005, 3, 1);
        step(1, 1, 0, 16'h0000, 16'h0005, 16'h0005, 16'h0005, 3, 1);
        step(1, 0, 0, 16'h0000, 16'h0006, 16'h0006, 16'h0005, 4, 1);
        step(1, 0, 1, 16'h0020, 16'h0020, 16'h0007, 16'h0006, 4, 2);
        step(1, 0, 1, 16'h0100, 16'h0100, 16'h0021, 16'h0007, 4, 3);
        step(1, 1, 1, 16'h0300, 16'h0300, 16'h0021, 16'h0021, 4, 4);
        step(1, 0, 0, 16'h0000, 16'h0301, 16'h0301, 16'h0021, 5, 4);
        step(1, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0302, 16'h0301, 5, 5);
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0302, 6, 5);
        step(1, 0, 0, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 7, 5);
        for (int i = 1; i <= 20; i++)
            step(1, 0, 0, 16'h0000, 16'(1 + i), 16'(1 + i), 16'(i), 4'((7 + i > 15) ? 15 : 7 + i), 5);
        for (int i = 1; i <= 17; i++)
            step(1, 0, 1, 16'(16'h0040 + i), 16'(16'h0040 + i),
                 (i == 1) ? 16'h0016 : 16'(16'h0040 + i),
                 (i == 1) ? 16'h0015 : (i == 2) ? 16'h0016 : 16'(16'h0040 + i - 1),
                 15, 4'((5 + i > 15) ? 15 : 5 + i));
        step(1, 0, 1, 16'h0042, 16'h0042, 16'h0052, 16'h0051, 15, 15);
        @(posedge clk);
        #3;
        rst_n = 0;
        flow_change_ID_EX = 0;
        push(16'h0010, 16'h0000, 16'h0000, 0, 0);
        probe = 1;
        #1 probe = 0;
        step(0, 1, 1, 16'h1234, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        step(1, 0, 0, 16'h0000, 16'h0011, 16'h0011, 16'h0000, 1, 0);
        step(1, 0, 0, 16'h0000, 16'h0012, 16'h0012, 16'h0011, 2, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
